// File: rtl/onehot_state_monitor.sv
// Checks a ring-sequenced one-hot state vector (one-hot-ness and legal successor) and keeps debug status.
// All outputs are registered with 1-cycle latency; the block never stalls the controller.
module onehot_state_monitor #(
  parameter int N          = 4,
  parameter int CNT_W      = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [N-1:0]         state_in,
  output logic                 err_not_onehot,
  output logic                 err_bad_trans,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     err_count,
  output logic [N-1:0]         first_err_state,
  output logic [1:0]           first_err_code,
  output logic [$clog2(N)-1:0] cur_index,
  output logic                 index_valid
);

  localparam int IW = $clog2(N);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;
  localparam logic [N-1:0]     ONE     = N'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       fsm_q, fsm_d;
  logic [N-1:0]     prev_q, prev_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             no_q, no_d;
  logic             bt_q, bt_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     fst_q, fst_d;
  logic [1:0]       fcode_q, fcode_d;

  logic          is_onehot;
  logic          legal;
  logic [N-1:0]  succ;
  logic [IW-1:0] idx_calc;

  always_comb begin
    is_onehot = (state_in != '0) && ((state_in & (state_in - ONE)) == '0);
    succ      = {prev_q[N-2:0], prev_q[N-1]};
    legal     = (state_in == succ) || (ALLOW_HOLD && (state_in == prev_q));
    idx_calc  = '0;
    for (int i = 0; i < N; i++) begin
      if (state_in[i]) idx_calc = IW'(i);
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    prev_d   = prev_q;
    idx_d    = idx_q;
    vld_d    = vld_q;
    no_d     = 1'b0;
    bt_d     = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    fst_d    = fst_q;
    fcode_d  = fcode_q;

    if (!enable) begin
      fsm_d = IDLE;
    end else if (!is_onehot) begin
      no_d   = 1'b1;
      fsm_d  = IDLE;
      prev_d = '0;
      idx_d  = '0;
      vld_d  = 1'b0;
    end else begin
      bt_d   = (fsm_q == TRACK) && !legal;
      fsm_d  = TRACK;
      prev_d = state_in;
      idx_d  = idx_calc;
      vld_d  = 1'b1;
    end

    // clear wins over a same-cycle error: the pulse still fires but nothing is recorded
    if (clear) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
      fst_d    = '0;
      fcode_d  = 2'b00;
    end else if (no_d || bt_d) begin
      sticky_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (!sticky_q) begin
        fst_d   = state_in;
        fcode_d = no_d ? 2'b01 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q    <= IDLE;
      prev_q   <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      no_q     <= 1'b0;
      bt_q     <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      fst_q    <= '0;
      fcode_q  <= 2'b00;
    end else begin
      fsm_q    <= fsm_d;
      prev_q   <= prev_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      no_q     <= no_d;
      bt_q     <= bt_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      fst_q    <= fst_d;
      fcode_q  <= fcode_d;
    end
  end

  assign err_not_onehot  = no_q;
  assign err_bad_trans   = bt_q;
  assign err_sticky      = sticky_q;
  assign err_count       = cnt_q;
  assign first_err_state = fst_q;
  assign first_err_code  = fcode_q;
  assign cur_index       = idx_q;
  assign index_valid     = vld_q;

endmodule

// File: tb/tb_onehot_state_monitor.sv
// Drives three monitor variants (default, hold-allowed, 2-bit counter) with the same stimulus
// and compares every output against a behavioural model after each clock.
module tb_onehot_state_monitor;

  logic       clk = 1'b0;
  logic       reset, enable, clear;
  logic [3:0] state_in;

  logic       no_w     [3];
  logic       bt_w     [3];
  logic       sticky_w [3];
  logic [7:0] cnt_w    [3];
  logic [1:0] cnt_s;
  logic [3:0] fst_w    [3];
  logic [1:0] fcode_w  [3];
  logic [1:0] idx_w    [3];
  logic       vld_w    [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_state_monitor #(.N(4), .CNT_W(8), .ALLOW_HOLD(1'b0)) u_base (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state_in(state_in),
    .err_not_onehot(no_w[0]), .err_bad_trans(bt_w[0]), .err_sticky(sticky_w[0]),
    .err_count(cnt_w[0]), .first_err_state(fst_w[0]), .first_err_code(fcode_w[0]),
    .cur_index(idx_w[0]), .index_valid(vld_w[0]));

  onehot_state_monitor #(.N(4), .CNT_W(8), .ALLOW_HOLD(1'b1)) u_hold (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state_in(state_in),
    .err_not_onehot(no_w[1]), .err_bad_trans(bt_w[1]), .err_sticky(sticky_w[1]),
    .err_count(cnt_w[1]), .first_err_state(fst_w[1]), .first_err_code(fcode_w[1]),
    .cur_index(idx_w[1]), .index_valid(vld_w[1]));

  onehot_state_monitor #(.N(4), .CNT_W(2), .ALLOW_HOLD(1'b0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .state_in(state_in),
    .err_not_onehot(no_w[2]), .err_bad_trans(bt_w[2]), .err_sticky(sticky_w[2]),
    .err_count(cnt_s), .first_err_state(fst_w[2]), .first_err_code(fcode_w[2]),
    .cur_index(idx_w[2]), .index_valid(vld_w[2]));

  assign cnt_w[2] = {6'b0, cnt_s};

  // Reference model: tracks ring position as an integer, one copy per variant
  int hold_ok [3] = '{0, 1, 0};
  int cnt_max [3] = '{255, 255, 3};
  int m_have [3];
  int m_ref  [3];
  int m_idx  [3];
  int m_vld  [3];
  int m_no   [3];
  int m_bt   [3];
  int m_stk  [3];
  int m_cnt  [3];
  int m_fst  [3];
  int m_fcd  [3];

  function automatic int bit_pos(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic model(input int k, input logic r, input logic e, input logic c, input logic [3:0] s);
    int ix;
    bit oh;
    if (r) begin
      m_have[k] = 0; m_ref[k] = 0; m_idx[k] = 0; m_vld[k] = 0; m_no[k] = 0; m_bt[k] = 0;
      m_stk[k] = 0; m_cnt[k] = 0; m_fst[k] = 0; m_fcd[k] = 0;
      return;
    end
    m_no[k] = 0;
    m_bt[k] = 0;
    if (e) begin
      oh = ($countones(s) == 1);
      ix = bit_pos(s);
      if (!oh) begin
        m_no[k] = 1; m_have[k] = 0; m_idx[k] = 0; m_vld[k] = 0;
      end else begin
        if (m_have[k] != 0 && !(ix == (m_ref[k] + 1) % 4 || (hold_ok[k] != 0 && ix == m_ref[k])))
          m_bt[k] = 1;
        m_have[k] = 1; m_ref[k] = ix; m_idx[k] = ix; m_vld[k] = 1;
      end
    end else begin
      m_have[k] = 0;
    end
    if (c) begin
      m_stk[k] = 0; m_cnt[k] = 0; m_fst[k] = 0; m_fcd[k] = 0;
    end else if (m_no[k] != 0 || m_bt[k] != 0) begin
      if (m_stk[k] == 0) begin
        m_fst[k] = int'(s);
        m_fcd[k] = (m_no[k] != 0) ? 1 : 2;
      end
      m_stk[k] = 1;
      if (m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
    end
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h at %0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic c, input logic [3:0] s);
    reset = r; enable = e; clear = c; state_in = s;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      model(k, r, e, c, s);
      chk("err_not_onehot", k, 32'(no_w[k]), 32'(m_no[k]));
      chk("err_bad_trans", k, 32'(bt_w[k]), 32'(m_bt[k]));
      chk("err_sticky", k, 32'(sticky_w[k]), 32'(m_stk[k]));
      chk("err_count", k, 32'(cnt_w[k]), 32'(m_cnt[k]));
      chk("first_err_state", k, 32'(fst_w[k]), 32'(m_fst[k]));
      chk("first_err_code", k, 32'(fcode_w[k]), 32'(m_fcd[k]));
      chk("cur_index", k, 32'(idx_w[k]), 32'(m_idx[k]));
      chk("index_valid", k, 32'(vld_w[k]), 32'(m_vld[k]));
    end
  endtask

  initial begin
    int ri;
    int sel;
    logic [3:0] s;
    logic e, c, r;

    // Normal ring
    step(1, 0, 0, 4'h0);
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'b0001);
    step(0, 1, 0, 4'b0010);
    step(0, 1, 0, 4'b0100);
    step(0, 1, 0, 4'b1000);
    step(0, 1, 0, 4'b0001);
    // Not one-hot, then recovery from IDLE
    step(0, 1, 0, 4'b0000);
    step(0, 1, 0, 4'b0011);
    step(0, 1, 0, 4'b0001);
    // Bad transition after a fresh reset
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'b0001);
    step(0, 1, 0, 4'b0100);
    step(0, 1, 0, 4'b1000);
    // Hold rule
    step(1, 0, 0, 4'h0);
    step(0, 1, 0, 4'b0010);
    step(0, 1, 0, 4'b0010);
    // Saturation, then clear colliding with an error
    for (int i = 0; i < 5; i++) step(0, 1, 0, 4'b0000);
    step(0, 1, 1, 4'b0101);
    step(0, 1, 0, 4'b0001);
    // Reset mid-ring
    step(0, 1, 0, 4'b0010);
    step(0, 1, 0, 4'b0100);
    step(1, 1, 0, 4'b0100);
    step(0, 1, 0, 4'b1000);
    // Enable dropped with garbage input
    step(0, 0, 0, 4'b1111);
    step(0, 0, 0, 4'b0110);
    step(0, 1, 0, 4'b0001);

    // Randomised ring traffic with occasional faults, clears, enable drops and resets
    ri = 0;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 6) begin
        ri = (ri + 1) % 4;
        s = 4'b0001 << ri;
      end else if (sel == 7) begin
        s = 4'b0001 << ri;
      end else if (sel == 8) begin
        ri = int'($urandom_range(0, 3));
        s = 4'b0001 << ri;
      end else begin
        s = 4'($urandom_range(0, 15));
      end
      e = ($urandom_range(0, 15) != 0);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 39) == 0);
      step(r, e, c, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_state_monitor.md
Name: onehot_state_monitor

Overview:
- Downstream consumer of the one-hot state register of the ring-sequenced controller (0001 -> 0010 -> 0100 -> 1000 -> 0001).
- Samples the state every clock and checks two things:
  - the value is one-hot;
  - each step is a legal ring transition.
- Reports per-cycle error pulses, a sticky error flag, a saturating error count, a first-error snapshot and the binary index of the current state.
- Synthesizable replacement for the simulation-only one-hot property, for use in silicon debug and status registers.

Parameters:
- N, 4, state vector width (number of one-hot states), N >= 2.
- CNT_W, 8, error counter width.
- ALLOW_HOLD, 0, 1 = repeating the same state is a legal transition; 0 = the state must advance every sampled cycle.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sample and check state_in this cycle.
- clear  in  1  synchronous clear of err_sticky, err_count and the first-error capture.
- state_in  in  N  one-hot state vector from the controller.
- err_not_onehot  out  1  one-cycle pulse: the sampled value was not one-hot.
- err_bad_trans  out  1  one-cycle pulse: the sampled value was one-hot but an illegal successor.
- err_sticky  out  1  set on any error, held until clear or reset.
- err_count  out  CNT_W  total errors, saturating.
- first_err_state  out  N  state_in value at the first error since reset or clear.
- first_err_code  out  2  01 = not one-hot, 10 = bad transition, 00 = none.
- cur_index  out  $clog2(N)  binary index of the set bit in the last valid sample.
- index_valid  out  1  cur_index is meaningful.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. While reset = 1, every output and internal register is 0 and the FSM is IDLE.
- Latency: all outputs are registered. A sample on edge k is reflected on the outputs after edge k, i.e. 1-cycle latency.
- One-hot test: state_in != 0 and (state_in & (state_in - 1)) == 0, computed at width N.
- Legal successor of P: rotate-left-by-1 of P, so MSB wraps to bit 0. If ALLOW_HOLD = 1, P itself is also legal.
- FSM states:
  - IDLE: no reference sample held.
  - TRACK: prev register holds the last one-hot sample.
- FSM transitions (evaluated only when enable = 1):
  - IDLE, one-hot sample -> TRACK; prev <= state_in; no transition check.
  - IDLE, non-one-hot sample -> IDLE; err_not_onehot pulse.
  - TRACK, non-one-hot sample -> IDLE; err_not_onehot pulse; prev is discarded.
  - TRACK, one-hot sample, legal successor -> TRACK; prev <= state_in.
  - TRACK, one-hot sample, illegal successor -> TRACK; err_bad_trans pulse; prev <= state_in (resynchronise to the new state).
- enable = 0:
  - FSM -> IDLE.
  - Both error pulses are 0.
  - cur_index and index_valid are held.
  - Sticky flag, count and capture are held.
- At most one error per cycle: err_bad_trans is evaluated only for one-hot samples.
- cur_index and index_valid:
  - One-hot sample: cur_index <= index of the set bit, index_valid <= 1.
  - Non-one-hot sample: cur_index <= 0, index_valid <= 0.
- err_count:
  - Increments by 1 per error.
  - Saturates at 2^CNT_W - 1 and never wraps.
- First-error capture:
  - Loads first_err_state and first_err_code on an error only if err_sticky = 0 before that edge.
  - Later errors leave the capture unchanged.
- clear:
  - Zeroes err_sticky, err_count, first_err_state and first_err_code.
  - clear has priority over an error in the same cycle: that error still produces its pulse, but it is not counted, not made sticky and not captured.
  - clear does not affect the FSM, prev, cur_index or index_valid.
- Reset mid-run: all state returns to 0 and IDLE on that edge. The first sample after reset is never transition-checked.

Test Plan:
- Normal ring: reset 2 cycles, then enable = 1 with 0001, 0010, 0100, 1000, 0001 -> no error pulses; cur_index 0, 1, 2, 3, 0 one cycle after each sample; index_valid = 1; err_count = 0.
- Not one-hot: in the ring, drive 0000, then 0011 -> err_not_onehot pulses on both; err_count = 2; first_err_state = 0000; first_err_code = 01; index_valid = 0; next 0001 gives no err_bad_trans because the FSM was in IDLE.
- Bad transition: drive 0001 then 0100 -> err_bad_trans pulse; err_count = 1; first_err_code = 10; first_err_state = 0100; then 1000 gives no error.
- Hold rule: 0010, 0010 with ALLOW_HOLD = 0 -> err_bad_trans pulse; repeat with ALLOW_HOLD = 1 -> no error.
- Saturation and clear:
  - CNT_W = 2, drive 5 consecutive 0000 samples -> err_count = 3.
  - Assert clear together with a 0101 sample -> err_not_onehot = 1, but err_count = 0, err_sticky = 0 and first_err_code = 00.
- Reset and enable: reset mid-ring after 0100 -> all outputs 0; then 1000 is accepted without error. Drop enable for 2 cycles with a garbage state_in -> no pulses; re-enable with 0001 -> no transition error.
